// File: rtl/lsu_mem_pkg.sv
// Shared types and helpers for the LSU-to-bus bridge: FSM states, access
// size encodings and the alignment rule applied before a bus request is issued.
package lsu_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } size_e;

    // The spare encoding 2'b11 behaves as a word access.
    function automatic size_e decode_size(input logic [1:0] mask);
        case (mask)
            2'b00:   return SIZE_B;
            2'b01:   return SIZE_H;
            default: return SIZE_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input size_e size, input logic [1:0] off);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return off[0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the LSU's low-aligned data and the 32-bit bus:
// write strobes, write-data replication and read-data right alignment.
module lsu_lane_align
    import lsu_mem_pkg::*;
(
    input  size_e       size_i,
    input  logic [1:0]  wr_off_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  rd_off_i,
    input  logic [31:0] rdata_raw_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        wstrb_o = 4'b0000;
        wdata_o = '0;
        case (size_i)
            SIZE_B: begin
                wstrb_o = 4'b0001 << wr_off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            SIZE_H: begin
                wstrb_o = 4'b0011 << wr_off_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Sign/zero extension is left to the LSU; only the lane shift happens here.
    assign rdata_o = rdata_raw_i >> {rd_off_i, 3'b000};

endmodule

// File: rtl/lsu_mem_bridge.sv
// Turns the LSU's single-cycle memory port into a valid/ready request and
// response-valid bus transaction, stalling the pipeline until it completes.
module lsu_mem_bridge
    import lsu_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  mask,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    // One spare count value lets a REQ accepted on the last cycle still be
    // judged in WAIT without the counter wrapping.
    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [31:0]      addr_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    size_e       size;
    logic        access;
    logic        misaligned;
    logic        start;
    logic [3:0]  lane_wstrb;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    assign size       = decode_size(mask);
    assign access     = mem_ren | mem_wen;
    assign misaligned = is_misaligned(size, addr[1:0]);
    assign start      = (state_q == ST_IDLE) && access && !misaligned;

    lsu_lane_align u_align (
        .size_i      (size),
        .wr_off_i    (addr[1:0]),
        .wdata_i     (wdata),
        .rd_off_i    (addr_q[1:0]),
        .rdata_raw_i (bus_rdata),
        .wstrb_o     (lane_wstrb),
        .wdata_o     (lane_wdata),
        .rdata_o     (lane_rdata)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        err_d         = 1'b0;
        stall         = 1'b0;
        misalign      = 1'b0;
        bus_req_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_REQ;
                        cnt_d   = '0;
                        rdata_d = '0;
                    end
                end
            end
            ST_REQ: begin
                stall         = 1'b1;
                bus_req_valid = 1'b1;
                cnt_d         = cnt_q + 1'b1;
                if (bus_req_ready) begin
                    state_d = ST_WAIT;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + 1'b1;
                // A response on the expiry cycle still completes normally.
                if (bus_rsp_valid) begin
                    state_d = ST_DONE;
                    if (!we_q) rdata_d = lane_rdata;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request payload is frozen on the IDLE->REQ edge so it cannot move
    // while bus_req_valid is waiting for ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= 4'b0000;
        end else if (start) begin
            addr_q  <= addr;
            we_q    <= mem_wen;
            wdata_q <= mem_wen ? lane_wdata : '0;
            wstrb_q <= mem_wen ? lane_wstrb : 4'b0000;
        end
    end

    assign bus_we    = we_q;
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wdata = wdata_q;
    assign bus_wstrb = wstrb_q;
    assign bus_err   = err_q;
    assign rdata     = (state_q == ST_DONE) ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge: loads, stores, misalignment, timeout
// and reset in the middle of a transaction, with hand-computed expectations.
module tb_lsu_mem_bridge;

    logic        clk;
    logic        rst_n;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mask;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        bus_err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the most recent access() call.
    int          r_stall;
    int          r_req;
    logic        r_done;
    logic [31:0] r_rdata;
    logic        r_mis;
    logic        r_err;
    logic [31:0] r_addr;
    logic        r_we;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    lsu_mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_ren       (mem_ren),
        .mem_wen       (mem_wen),
        .addr          (addr),
        .wdata         (wdata),
        .mask          (mask),
        .rdata         (rdata),
        .stall         (stall),
        .misalign      (misalign),
        .bus_err       (bus_err),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .bus_rsp_valid (bus_rsp_valid),
        .bus_rdata     (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one LSU access and plays the bus side: ready while a request is
    // shown (if give_ready), a one-cycle response on the first WAIT cycle.
    // Returns once stall is low, sampling everything on falling edges.
    task automatic access(input logic ren, input logic wen, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] m,
                          input logic [31:0] brd, input logic give_ready);
        logic seen_req;
        @(posedge clk);
        #1;
        mem_ren = ren;
        mem_wen = wen;
        addr    = a;
        wdata   = wd;
        mask    = m;
        r_stall = 0;
        r_req   = 0;
        r_done  = 1'b0;
        seen_req = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b0;
            if (bus_req_valid) begin
                seen_req = 1'b1;
                r_req++;
                r_addr  = bus_addr;
                r_we    = bus_we;
                r_wdata = bus_wdata;
                r_wstrb = bus_wstrb;
                bus_req_ready = give_ready;
            end else if (stall && seen_req) begin
                bus_rsp_valid = 1'b1;
                bus_rdata     = brd;
            end
            if (stall) begin
                r_stall++;
            end else begin
                r_rdata = rdata;
                r_mis   = misalign;
                r_err   = bus_err;
                r_done  = 1'b1;
                break;
            end
        end
        check("access_completes", {31'd0, r_done}, 32'd1);
    endtask

    task automatic idle_inputs();
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        addr    = '0;
        wdata   = '0;
        mask    = 2'b00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"},  {31'd0, stall}, 32'd0);
        check({tag, "_valid"},  {31'd0, bus_req_valid}, 32'd0);
        check({tag, "_we"},     {31'd0, bus_we}, 32'd0);
        check({tag, "_addr"},   bus_addr, 32'h0);
        check({tag, "_wdata"},  bus_wdata, 32'h0);
        check({tag, "_wstrb"},  {28'd0, bus_wstrb}, 32'h0);
        check({tag, "_rdata"},  rdata, 32'h0);
        check({tag, "_mis"},    {31'd0, misalign}, 32'd0);
        check({tag, "_err"},    {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = '0;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Word load, best case: 3 stall cycles, data right through.
        access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'b10, 32'hDEAD_BEEF, 1'b1);
        check("wload_stall",  r_stall, 3);
        check("wload_rdata",  r_rdata, 32'hDEAD_BEEF);
        check("wload_addr",   r_addr, 32'h0000_0100);
        check("wload_wstrb",  {28'd0, r_wstrb}, 32'h0);
        check("wload_we",     {31'd0, r_we}, 32'd0);

        // Byte store to the top lane; rdata stays 0 on a write.
        access(1'b0, 1'b1, 32'h0000_0203, 32'h0000_00A5, 2'b00, 32'h1234_5678, 1'b1);
        check("bstore_wstrb", {28'd0, r_wstrb}, 32'h8);
        check("bstore_wdata", r_wdata, 32'hA5A5_A5A5);
        check("bstore_we",    {31'd0, r_we}, 32'd1);
        check("bstore_addr",  r_addr, 32'h0000_0200);
        check("bstore_rdata", r_rdata, 32'h0);

        // Half load from the upper half, back-to-back with the store.
        access(1'b1, 1'b0, 32'h0000_0302, 32'h0, 2'b01, 32'h8001_FFFF, 1'b1);
        check("hload_rdata",  r_rdata, 32'h0000_8001);
        check("hload_addr",   r_addr, 32'h0000_0300);

        // Half store to the upper half; mask 11 word store.
        access(1'b0, 1'b1, 32'h0000_0106, 32'hFFFF_1234, 2'b01, 32'h0, 1'b1);
        check("hstore_wstrb", {28'd0, r_wstrb}, 32'hC);
        check("hstore_wdata", r_wdata, 32'h1234_1234);
        access(1'b0, 1'b1, 32'h0000_0408, 32'hCAFE_F00D, 2'b11, 32'h0, 1'b1);
        check("w11_wstrb",    {28'd0, r_wstrb}, 32'hF);
        check("w11_wdata",    r_wdata, 32'hCAFE_F00D);

        // Byte load from lane 1.
        access(1'b1, 1'b0, 32'h0000_0501, 32'h0, 2'b00, 32'h1122_3344, 1'b1);
        check("bload_rdata",  r_rdata, 32'h0011_2233);

        // Misaligned word store: pulse, no stall, no request.
        access(1'b0, 1'b1, 32'h0000_0101, 32'h0, 2'b10, 32'h0, 1'b1);
        check("mis_pulse",    {31'd0, r_mis}, 32'd1);
        check("mis_stall",    r_stall, 0);
        check("mis_noreq",    r_req, 0);
        // Misaligned half load.
        access(1'b1, 1'b0, 32'h0000_0103, 32'h0, 2'b01, 32'h0, 1'b1);
        check("mis_half",     {31'd0, r_mis}, 32'd1);
        check("mis_half_req", r_req, 0);

        // Ready withheld: 8 REQ cycles, then DONE with bus_err and rdata 0.
        access(1'b1, 1'b0, 32'h0000_0600, 32'h0, 2'b10, 32'hFFFF_FFFF, 1'b0);
        check("to_req_cycles", r_req, 8);
        check("to_stall",      r_stall, 9);
        check("to_err",        {31'd0, r_err}, 32'd1);
        check("to_rdata",      r_rdata, 32'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        check("to_err_pulse",  {31'd0, bus_err}, 32'd0);
        check("to_idle_valid", {31'd0, bus_req_valid}, 32'd0);
        check("to_idle_stall", {31'd0, stall}, 32'd0);

        // Reset while in WAIT, then a stray response after release.
        @(posedge clk);
        #1;
        mem_ren = 1'b1;
        addr    = 32'h0000_0700;
        mask    = 2'b10;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_req", {31'd0, bus_req_valid}, 32'd1);
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        check("rst_in_wait", {31'd0, stall & ~bus_req_valid}, 32'd1);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        bus_rsp_valid = 1'b1;
        bus_rdata     = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        check("late_rsp_rdata", rdata, 32'h0);
        check("late_rsp_stall", {31'd0, stall}, 32'd0);
        check("late_rsp_valid", {31'd0, bus_req_valid}, 32'd0);

        access(1'b1, 1'b0, 32'h0000_0800, 32'h0, 2'b10, 32'h0BAD_F00D, 1'b1);
        check("post_rst_rdata", r_rdata, 32'h0BAD_F00D);
        check("post_rst_stall", r_stall, 3);
        check("post_rst_err",   {31'd0, r_err}, 32'd0);

        @(posedge clk);
        #1;
        idle_inputs();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
